// File: rtl/pe_act_broadcast_engine.sv
// rtl/pe_act_broadcast_engine.sv - walks the local activation regfile and broadcasts surviving entries to the router
module pe_act_broadcast_engine #(
  parameter int ACT_IDX_W = 4,
  parameter int DATA_W = 16,
  parameter int PE_IDX_W = 6,
  parameter int ROUTER_ADDR_W = 4,
  parameter logic [ROUTER_ADDR_W-1:0] BCAST_ADDR = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PE_IDX_W-1:0]           PE_IDX,
  input  logic                          start,
  input  logic [ACT_IDX_W:0]            in_act_no,
  input  logic                          skip_zero,
  input  logic [2**ACT_IDX_W-1:0]       in_act_zeros,
  output logic                          in_act_read_en,
  output logic [ACT_IDX_W-1:0]          in_act_read_addr,
  input  logic [DATA_W-1:0]             in_act_read_data,
  input  logic                          router_rdy,
  output logic                          act_send_en,
  output logic [ROUTER_ADDR_W-1:0]      act_send_addr,
  output logic [DATA_W-1:0]             act_send_data,
  output logic [PE_IDX_W+ACT_IDX_W-1:0] act_send_idx,
  output logic                          busy,
  output logic                          done,
  output logic [ACT_IDX_W:0]            sent_cnt
);

  localparam int ACT_NO = 2**ACT_IDX_W;
  localparam logic [ACT_IDX_W:0] ACT_LIM = {1'b1, {ACT_IDX_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LD, S_SEND, S_DONE} state_t;

  state_t              state;
  logic [ACT_NO-1:0]   mask;
  logic [ACT_NO-1:0]   start_mask;
  logic [ACT_IDX_W:0]  act_lim;
  logic [ACT_IDX_W-1:0] start_low;
  logic [ACT_IDX_W-1:0] rest_low;

  function automatic logic [ACT_IDX_W-1:0] lowest(input logic [ACT_NO-1:0] m);
    lowest = '0;
    for (int i = ACT_NO - 1; i >= 0; i--) begin
      if (m[i]) lowest = ACT_IDX_W'(i);
    end
  endfunction

  // Pending mask a start would latch; oversized counts clamp to the full file.
  always_comb begin
    act_lim = (in_act_no > ACT_LIM) ? ACT_LIM : in_act_no;
    start_mask = '0;
    for (int i = 0; i < ACT_NO; i++) begin
      start_mask[i] = ((ACT_IDX_W+1)'(i) < act_lim) && !(skip_zero && in_act_zeros[i]);
    end
    start_low = lowest(start_mask);
    rest_low  = lowest(mask);
  end

  // Gated by reset so a send caught by a mid-pass reset never transfers.
  assign act_send_en   = (state == S_SEND) && router_rdy && rst;
  assign act_send_addr = BCAST_ADDR;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      mask             <= '0;
      in_act_read_en   <= 1'b0;
      in_act_read_addr <= '0;
      act_send_data    <= '0;
      act_send_idx     <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      sent_cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask     <= start_mask;
            sent_cnt <= '0;
            busy     <= 1'b1;
            if (|start_mask) begin
              state            <= S_RD;
              in_act_read_en   <= 1'b1;
              in_act_read_addr <= start_low;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RD: begin
          in_act_read_en         <= 1'b0;
          mask[in_act_read_addr] <= 1'b0;
          act_send_idx           <= {PE_IDX, in_act_read_addr};
          state                  <= S_LD;
        end
        S_LD: begin
          act_send_data <= in_act_read_data;
          state         <= S_SEND;
        end
        S_SEND: begin
          if (router_rdy) begin
            sent_cnt <= sent_cnt + 1'b1;
            if (|mask) begin
              state            <= S_RD;
              in_act_read_en   <= 1'b1;
              in_act_read_addr <= rest_low;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_act_broadcast_engine.sv
// tb/tb_pe_act_broadcast_engine.sv - randomized self-checking bench with a queue-based reference model
module tb_pe_act_broadcast_engine;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int PW = 6;
  localparam int RW = 4;
  localparam int NO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [PW-1:0] pe_idx;
  logic start;
  logic [AW:0] in_act_no;
  logic skip_zero;
  logic [NO-1:0] in_act_zeros;
  logic in_act_read_en;
  logic [AW-1:0] in_act_read_addr;
  logic [DW-1:0] in_act_read_data;
  logic router_rdy;
  logic act_send_en;
  logic [RW-1:0] act_send_addr;
  logic [DW-1:0] act_send_data;
  logic [PW+AW-1:0] act_send_idx;
  logic busy;
  logic done;
  logic [AW:0] sent_cnt;

  pe_act_broadcast_engine dut (
    .clk(clk), .rst(rst), .PE_IDX(pe_idx), .start(start), .in_act_no(in_act_no),
    .skip_zero(skip_zero), .in_act_zeros(in_act_zeros), .in_act_read_en(in_act_read_en),
    .in_act_read_addr(in_act_read_addr), .in_act_read_data(in_act_read_data),
    .router_rdy(router_rdy), .act_send_en(act_send_en), .act_send_addr(act_send_addr),
    .act_send_data(act_send_data), .act_send_idx(act_send_idx), .busy(busy), .done(done),
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf [NO];
  always @(posedge clk) if (in_act_read_en) in_act_read_data <= rf[in_act_read_addr];

  int n_chk = 0;
  int n_fail = 0;
  int rd_q[$];
  logic [DW-1:0] dq[$];
  logic [PW+AW-1:0] iq[$];
  int send_rel[$];
  logic [DW-1:0] got_d[$];
  logic [PW+AW-1:0] got_i[$];
  int exp_cnt = 0;
  int done_rel = -1;
  int ncyc = 0;
  int start_cyc = 0;
  int model_sent = 0;
  bit started = 0;
  bit in_pass = 0;
  bit checking = 0;
  bit rdy_rnd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every cycle, DUT behaviour against the pass model.
  always @(negedge clk) begin
    int rel;
    ncyc++;
    rel = ncyc - start_cyc;
    if (checking) begin
      if (started && rel >= 1) begin
        in_pass = 1;
        started = 0;
        model_sent = 0;
      end
      chk("busy", busy, in_pass);
      chk("sent_cnt", sent_cnt, model_sent);
      if (!in_pass) chk("done_idle", done, 0);
      if (act_send_en) begin
        chk("send_rdy", router_rdy, 1);
        chk("send_rst", rst, 1);
        if (dq.size() == 0) chk("unexpected_send", act_send_en, 0);
        else begin
          chk("send_data", act_send_data, dq.pop_front());
          chk("send_idx", act_send_idx, iq.pop_front());
          chk("send_addr", act_send_addr, 4'hF);
          send_rel.push_back(rel);
          got_d.push_back(act_send_data);
          got_i.push_back(act_send_idx);
          model_sent++;
        end
      end
      if (in_act_read_en) begin
        if (rd_q.size() == 0) chk("unexpected_read", in_act_read_en, 0);
        else chk("read_addr", in_act_read_addr, rd_q.pop_front());
      end
      if (done && in_pass) begin
        done_rel = rel;
        chk("done_cnt", sent_cnt, exp_cnt);
        chk("done_left", dq.size(), 0);
        in_pass = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rnd) router_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_pass(input int n, input logic [NO-1:0] z, input logic sk);
    in_act_no = n[AW:0];
    in_act_zeros = z;
    skip_zero = sk;
    rd_q.delete(); dq.delete(); iq.delete();
    send_rel.delete(); got_d.delete(); got_i.delete();
    done_rel = -1;
    exp_cnt = 0;
    for (int i = 0; i < NO; i++) begin
      if (i < n && !(sk && z[i])) begin
        rd_q.push_back(i);
        dq.push_back(rf[i]);
        iq.push_back({pe_idx, AW'(i)});
        exp_cnt++;
      end
    end
    start = 1'b1;
    start_cyc = ncyc + 1;
    started = 1;
    @(posedge clk);
    #2;
    start = 1'b0;
    in_act_no = 5'($urandom);
    in_act_zeros = 16'($urandom);
    skip_zero = 1'($urandom);
  endtask

  task automatic wait_done(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      if (done_rel >= 0) break;
      @(posedge clk);
      #2;
    end
    chk("done_seen", (done_rel >= 0), 1);
    @(posedge clk);
    #2;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NO; i++) rf[i] = 16'h10 + 16'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NO; i++) rf[i] = 16'($urandom);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    router_rdy = 1'b0;
    pe_idx = 6'($urandom);
    in_act_no = 5'($urandom);
    in_act_zeros = 16'($urandom);
    skip_zero = 1'($urandom);
    fill_rand();

    repeat (3) begin
      @(negedge clk);
      chk("rst_read_en", in_act_read_en, 0);
      chk("rst_read_addr", in_act_read_addr, 0);
      chk("rst_send_en", act_send_en, 0);
      chk("rst_send_addr", act_send_addr, 4'hF);
      chk("rst_send_data", act_send_data, 0);
      chk("rst_send_idx", act_send_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sent_cnt", sent_cnt, 0);
      start = 1'($urandom);
      router_rdy = 1'($urandom);
      in_act_no = 5'($urandom);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    start = 1'b0;
    model_sent = 0;
    checking = 1;
    @(posedge clk);
    #2;

    // Dense pass
    pe_idx = 6'd3;
    fill_ramp();
    router_rdy = 1'b1;
    start_pass(4, '0, 1'b0);
    chk("dense_model_cnt", exp_cnt, 4);
    wait_done(60);
    chk("dense_nsend", send_rel.size(), 4);
    if (send_rel.size() == 4) begin
      chk("dense_t0", send_rel[0], 3);
      chk("dense_t1", send_rel[1], 6);
      chk("dense_t2", send_rel[2], 9);
      chk("dense_t3", send_rel[3], 12);
      chk("dense_d0", got_d[0], 16'h10);
      chk("dense_d3", got_d[3], 16'h13);
      chk("dense_i0", got_i[0], 10'h030);
      chk("dense_i3", got_i[3], 10'h033);
    end
    chk("dense_done_t", done_rel, 13);
    chk("dense_cnt", sent_cnt, 4);

    // Zero skip and its dense counterpart
    fill_rand();
    start_pass(16, 16'hFFF5, 1'b1);
    chk("skip_model_cnt", exp_cnt, 2);
    wait_done(60);
    chk("skip_nsend", got_i.size(), 2);
    if (got_i.size() == 2) begin
      chk("skip_i0", got_i[0][3:0], 1);
      chk("skip_i1", got_i[1][3:0], 3);
    end
    chk("skip_cnt", sent_cnt, 2);
    start_pass(16, 16'hFFF5, 1'b0);
    wait_done(100);
    chk("noskip_nsend", send_rel.size(), 16);
    chk("noskip_cnt", sent_cnt, 16);

    // Backpressure on the first SEND, cycles 3..7
    fill_ramp();
    router_rdy = 1'b0;
    start_pass(4, '0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    repeat (5) begin
      @(negedge clk);
      chk("bp_no_send", act_send_en, 0);
      chk("bp_data_hold", act_send_data, 16'h10);
      chk("bp_idx_hold", act_send_idx, 10'h030);
    end
    @(posedge clk);
    #2;
    router_rdy = 1'b1;
    wait_done(60);
    chk("bp_nsend", send_rel.size(), 4);
    if (send_rel.size() == 4) chk("bp_t0", send_rel[0], 8);
    chk("bp_done_t", done_rel, 18);
    chk("bp_cnt", sent_cnt, 4);

    // Empty and clamped passes
    start_pass(0, 16'($urandom), 1'($urandom));
    wait_done(20);
    chk("empty_done_t", done_rel, 1);
    chk("empty_nsend", send_rel.size(), 0);
    start_pass(31, 16'($urandom), 1'b0);
    chk("clamp_model_cnt", exp_cnt, 16);
    wait_done(100);
    chk("clamp_cnt", sent_cnt, 16);

    // Start while busy is ignored
    start_pass(4, '0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    start = 1'b1;
    in_act_no = 5'd2;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(60);
    chk("ign_done_t", done_rel, 13);
    chk("ign_nsend", send_rel.size(), 4);
    chk("ign_cnt", sent_cnt, 4);

    // Reset in the second SEND (cycle 6)
    start_pass(4, '0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    chk("mrst_nsend", send_rel.size(), 1);
    in_pass = 0;
    started = 0;
    model_sent = 0;
    rd_q.delete(); dq.delete(); iq.delete();
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_send_en", act_send_en, 0);
    @(posedge clk);
    #2;
    start_pass(4, '0, 1'b0);
    wait_done(60);
    chk("mrst_re_done_t", done_rel, 13);
    chk("mrst_re_cnt", sent_cnt, 4);

    // Randomized passes with random backpressure
    rdy_rnd = 1;
    for (int p = 0; p < 12; p++) begin
      pe_idx = 6'($urandom);
      fill_rand();
      start_pass(int'($urandom_range(0, 31)), 16'($urandom), 1'($urandom));
      wait_done(400);
    end
    rdy_rnd = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
